epochtv1_vram_arb: RTL
======================

// Module: epochtv1_vram_arb
// PURPOSE
//  Slot scheduler for the shared 2x8-bit VRAM bus (lane A = low byte, lane B = high byte) of the TV-1 video chip.
//  Shares each pixel-clock slot between a CPU port and the sprite pattern fetcher.
//  The CPU port has a one-entry posted write buffer with read forwarding.
//  Sprites have priority while rendering, with a bounded CPU starvation limit.
// PARAMETERS
//  CPU_MAX_WAIT  4   max consecutive sprite grants while a CPU access is pending during RENDER (1..15)
// PORTS
//  CLK       in   1   clock (XTAL*2)
//  RESB      in   1   synchronous active-low reset
//  CE        in   1   pixel clock enable; one slot = interval between CE edges
//  RENDER    in   1   1 = sprite-priority mode (pre-render/render rows)
//  CPU_REQ   in   1   CPU access request; held with CPU_WE/A/DI stable until granted
//  CPU_WE    in   1   1 = write, 0 = read
//  CPU_A     in   13  byte address; [12:1] = VRAM word, [0] = lane (0=A, 1=B)
//  CPU_DI    in   8   write data
//  CPU_GNT   out  1   request accepted at the CE edge ending this slot
//  CPU_DO    out  8   read data
//  CPU_DVAL  out  1   CPU_DO valid for this slot
//  SPR_REQ   in   1   sprite fetch request; held with SPR_A stable until granted
//  SPR_A     in   12  VRAM word address
//  SPR_GNT   out  1   fetch accepted at the CE edge ending this slot
//  SPR_D     out  16  {lane B, lane A} fetch data
//  SPR_DVAL  out  1   SPR_D valid for this slot
//  VAA/VBA   out  12  VRAM word address, lane A / lane B (always equal)
//  VAD_I/VBD_I in 8   lane read data
//  VAD_O/VBD_O out 8  lane write data (buffered write byte)
//  nVARD/nVBRD out 1  read strobe, active low
//  nVAWR/nVBWR out 1  write strobe, active low
// BEHAVIOUR
//  Reset (RESB=0 at a CLK edge, CE ignored) clears the following:
//   - write buffer emptied (a pending write is discarded)
//   - starvation counter = 0; CPU_DVAL = SPR_DVAL = 0; CPU_DO = SPR_D = 0
//   - with RESB low, all strobes are 1 and both GNT outputs are 0
//  GNT, the address mux and the strobes are combinational from the REQs plus registered state.
//  All state updates only at CLK edges with CE=1. CE is low between CE edges; GNT is a per-slot decision.
//  Write buffer (WB: valid, A[12:0], data):
//   - CPU write: GNT=1 if WB is empty, or if WB drains this slot; WB loads at the slot edge.
//   - If WB is full and not draining, GNT=0 (CPU waits).
//   - CPU read, WB full, WB.A == CPU_A: forwarded. GNT=1 with no bus slot.
//     CPU_DO = WB data and CPU_DVAL=1 in the next slot.
//   - CPU read, WB full, address mismatch: not eligible. WB drains first (write ordering).
//  Bus candidates: C = WB drain, else eligible CPU read; S = SPR_REQ.
//  Arbitration per slot:
//   - RENDER=0: C wins, else S.
//   - RENDER=1: S wins, unless C pending and counter == CPU_MAX_WAIT; then C wins.
//   - Counter: +1 (saturating) when S is granted with C pending; cleared when C is granted or C is absent.
//  Bus drive in the granted slot:
//   - WB drain: VxA = WB.A[12:1]; VxD_O = WB data. nVAWR=0 if WB.A[0]=0, else nVBWR=0. Reads stay high.
//   - CPU read: VxA = CPU_A[12:1]; nVARD=nVBRD=0. Lane is latched for return.
//   - Sprite: VxA = SPR_A; nVARD=nVBRD=0.
//   - Idle slot: all strobes 1; address holds its last value.
//  Read latency: data is sampled from VAD_I/VBD_I at the CE edge ending the grant slot.
//   - Presented with DVAL=1 for exactly the next slot (cleared at the following CE edge).
//   - CPU_DO = latched lane ? VBD_I : VAD_I.
//  Throughput: one bus access per slot. A requester may hold REQ after GNT for back-to-back grants.
//  Simultaneous events:
//   - A CPU write accepted in the same slot WB drains is legal (WB reloads).
//   - RENDER changes take effect in the slot in which they are sampled; the counter is not cleared.
// TESTING
//  1. RENDER=0: CPU read A=0x0013 with VBD_I=0x5A. VBA=0x009, nVBRD=0, GNT same slot; next slot CPU_DO=0x5A, CPU_DVAL=1.
//  2. CPU write 0x0200<-0x77 with RENDER=1, SPR_REQ held. GNT at once (WB empty). Bus shows 4 sprite slots, then nVAWR=0 at VAA=0x100 with VAD_O=0x77 in slot 5.
//  3. Two back-to-back CPU writes with RENDER=1 and SPR_REQ held. Second write GNT=0 until the first drains (slot 5); both land in order.
//  4. WB holds 0x0201=0x3C; CPU read 0x0201. GNT with no strobe asserted; next slot CPU_DO=0x3C. Read of 0x0202 instead waits for the drain.
//  5. SPR_REQ held with 8 consecutive SPR_A values, RENDER=1, no CPU traffic. 8 grants in 8 slots; each SPR_D = {VBD_I, VAD_I} one slot later.
//  6. RESB=0 mid-stream with WB full and DVAL=1. Next cycle WB empty, DVAL=0, strobes high; the discarded write never appears on the bus.

Source files
------------

// File: rtl/epochtv1_vram_arb_if.sv
// TV-1 VRAM arbiter bus bundle: CPU port, sprite fetch port and the 2x8-bit VRAM lanes.
interface epochtv1_vram_arb_if;
    localparam int unsigned CPU_AW = 13;
    localparam int unsigned VRAM_AW = 12;

    logic                 CPU_REQ;
    logic                 CPU_WE;
    logic [CPU_AW-1:0]    CPU_A;
    logic [7:0]           CPU_DI;
    logic                 CPU_GNT;
    logic [7:0]           CPU_DO;
    logic                 CPU_DVAL;

    logic                 SPR_REQ;
    logic [VRAM_AW-1:0]   SPR_A;
    logic                 SPR_GNT;
    logic [15:0]          SPR_D;
    logic                 SPR_DVAL;

    logic [VRAM_AW-1:0]   VAA;
    logic [VRAM_AW-1:0]   VBA;
    logic [7:0]           VAD_I;
    logic [7:0]           VBD_I;
    logic [7:0]           VAD_O;
    logic [7:0]           VBD_O;
    logic                 nVARD;
    logic                 nVBRD;
    logic                 nVAWR;
    logic                 nVBWR;

    // Requesters and VRAM device side
    modport master (
        output CPU_REQ, CPU_WE, CPU_A, CPU_DI,
        output SPR_REQ, SPR_A,
        output VAD_I, VBD_I,
        input  CPU_GNT, CPU_DO, CPU_DVAL,
        input  SPR_GNT, SPR_D, SPR_DVAL,
        input  VAA, VBA, VAD_O, VBD_O, nVARD, nVBRD, nVAWR, nVBWR
    );

    // Arbiter side
    modport slave (
        input  CPU_REQ, CPU_WE, CPU_A, CPU_DI,
        input  SPR_REQ, SPR_A,
        input  VAD_I, VBD_I,
        output CPU_GNT, CPU_DO, CPU_DVAL,
        output SPR_GNT, SPR_D, SPR_DVAL,
        output VAA, VBA, VAD_O, VBD_O, nVARD, nVBRD, nVAWR, nVBWR
    );
endinterface

// File: rtl/epochtv1_vram_arb.sv
// TV-1 VRAM slot scheduler: per-slot arbitration between a CPU port with a
// one-entry posted write buffer (read forwarding) and the sprite fetcher.
module epochtv1_vram_arb #(
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic CLK,
    input  logic RESB,
    input  logic CE,
    input  logic RENDER,
    epochtv1_vram_arb_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CPU_AW = 13;
    localparam int unsigned VRAM_AW = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef struct packed {
        logic              valid;
        logic [CPU_AW-1:0] addr;
        logic [7:0]        data;
    } wb_t;

    wb_t                 wb_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [VRAM_AW-1:0]  addr_q;
    logic                cpu_dval_q;
    logic [7:0]          cpu_do_q;
    logic                spr_dval_q;
    logic [15:0]         spr_d_q;

    logic                c_drain;
    logic                c_read;
    logic                c_pend;
    logic                fwd;
    logic                c_win;
    logic                s_win;
    logic                drain;
    logic                rd_win;
    logic                wr_gnt;
    logic [VRAM_AW-1:0]  addr_c;

    // Slot decision: candidates, winner, write acceptance and forwarding
    always_comb begin
        c_drain = wb_q.valid;
        c_read  = !wb_q.valid && bus.CPU_REQ && !bus.CPU_WE;
        c_pend  = c_drain || c_read;
        fwd     = RESB && wb_q.valid && bus.CPU_REQ && !bus.CPU_WE &&
                  (wb_q.addr == bus.CPU_A);
        c_win   = 1'b0;
        s_win   = 1'b0;
        if (RESB) begin
            if (!RENDER) begin
                c_win = c_pend;
                s_win = !c_pend && bus.SPR_REQ;
            end else begin
                c_win = c_pend && (!bus.SPR_REQ || (cnt_q == CNT_MAX));
                s_win = bus.SPR_REQ && !c_win;
            end
        end
        drain  = c_win && c_drain;
        rd_win = c_win && c_read;
        wr_gnt = RESB && bus.CPU_REQ && bus.CPU_WE && (!wb_q.valid || drain);
    end

    // Address mux; an idle slot keeps the previous address on the bus
    always_comb begin
        addr_c = addr_q;
        if (drain) begin
            addr_c = wb_q.addr[CPU_AW-1:1];
        end else if (rd_win) begin
            addr_c = bus.CPU_A[CPU_AW-1:1];
        end else if (s_win) begin
            addr_c = bus.SPR_A;
        end
    end

    assign bus.CPU_GNT  = wr_gnt || fwd || rd_win;
    assign bus.SPR_GNT  = s_win;
    assign bus.VAA      = addr_c;
    assign bus.VBA      = addr_c;
    assign bus.VAD_O    = wb_q.data;
    assign bus.VBD_O    = wb_q.data;
    assign bus.nVARD    = !(rd_win || s_win);
    assign bus.nVBRD    = !(rd_win || s_win);
    assign bus.nVAWR    = !(drain && !wb_q.addr[0]);
    assign bus.nVBWR    = !(drain && wb_q.addr[0]);
    assign bus.CPU_DO   = cpu_do_q;
    assign bus.CPU_DVAL = cpu_dval_q;
    assign bus.SPR_D    = spr_d_q;
    assign bus.SPR_DVAL = spr_dval_q;

    // Slot-edge state update: write buffer, starvation counter, read returns
    always_ff @(posedge CLK) begin
        if (!RESB) begin
            wb_q       <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            cpu_dval_q <= 1'b0;
            cpu_do_q   <= '0;
            spr_dval_q <= 1'b0;
            spr_d_q    <= '0;
        end else if (CE) begin
            if (wr_gnt) begin
                wb_q <= wb_t'{valid: 1'b1, addr: bus.CPU_A, data: bus.CPU_DI};
            end else if (drain) begin
                wb_q.valid <= 1'b0;
            end

            if (s_win && c_pend) begin
                cnt_q <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end

            addr_q     <= addr_c;
            cpu_dval_q <= fwd || rd_win;
            if (fwd) begin
                cpu_do_q <= wb_q.data;
            end else if (rd_win) begin
                cpu_do_q <= bus.CPU_A[0] ? bus.VBD_I : bus.VAD_I;
            end

            spr_dval_q <= s_win;
            if (s_win) begin
                spr_d_q <= {bus.VBD_I, bus.VAD_I};
            end
        end
    end
endmodule
